// File: rtl/mode_sweeper_pkg.sv
// mode_sweeper_pkg: shared state encodings, result flag indices and counter widths
package mode_sweeper_pkg;
    localparam int W_RECV = 60;
    localparam int W_ERR = 64;
    localparam int F_ERR = 0;
    localparam int F_TIMEOUT = 1;
    typedef enum logic [2:0] {
        S_IDLE, S_SETTLE, S_CLEAR, S_WAIT_INIT, S_DWELL, S_REPORT, S_NEXT, S_FINISH
    } state_t;
    function automatic int max3(input int a, input int b, input int c);
        return (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
    endfunction
endpackage

// File: rtl/mode_sweeper_if.sv
// mode_sweeper_if: sweep control, stimulus-block link and result handshake
interface mode_sweeper_if #(
    parameter int W_DWELL = 16,
    parameter int W_SETTLE = 8
);
    import mode_sweeper_pkg::*;
    logic start, abort, sub_sweep, phy_init, res_ready;
    logic [7:0] first_mode, last_mode;
    logic [W_DWELL-1:0] dwell;
    logic [W_SETTLE-1:0] settle;
    logic [W_RECV-1:0] recv_cnt;
    logic [W_ERR-1:0] err_cnt;
    logic [7:0] main_mode, sub_mode;
    logic clr, busy, done, aborted, cfg_err, res_valid, res_sub;
    logic [7:0] res_mode;
    logic [1:0] res_flags;
    logic [W_RECV-1:0] res_recv;
    logic [W_ERR-1:0] res_err;
    modport slave (
        input start, abort, sub_sweep, phy_init, res_ready, first_mode, last_mode,
        input dwell, settle, recv_cnt, err_cnt,
        output main_mode, sub_mode, clr, busy, done, aborted, cfg_err,
        output res_valid, res_sub, res_mode, res_flags, res_recv, res_err
    );
    modport master (
        output start, abort, sub_sweep, phy_init, res_ready, first_mode, last_mode,
        output dwell, settle, recv_cnt, err_cnt,
        input main_mode, sub_mode, clr, busy, done, aborted, cfg_err,
        input res_valid, res_sub, res_mode, res_flags, res_recv, res_err
    );
endinterface

// File: rtl/mode_sweeper_sweep_timer.sv
// sweep_timer: loadable down-counter that stops at zero and flags it
module sweep_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] val_i,
    output logic         zero_o
);
    logic [W-1:0] cnt_q;
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else if (load_i) cnt_q <= val_i;
        else if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
    end
    assign zero_o = cnt_q == '0;
endmodule

// File: rtl/mode_sweeper.sv
// mode_sweeper: steps MAIN_MODE/SUB_MODE over a range, measuring and reporting each step
module mode_sweeper #(
    parameter int W_DWELL = 16,
    parameter int W_SETTLE = 8,
    parameter int W_TIMEOUT = 10
) (
    input logic clk,
    input logic rst,
    mode_sweeper_if.slave bus
);
    import mode_sweeper_pkg::*;
    localparam int TW = max3(W_DWELL, W_SETTLE, W_TIMEOUT);
    // WAIT_INIT is entered one cycle after the load, so REPORT lands 2^W_TIMEOUT cycles after CLEAR
    localparam logic [TW-1:0] T_LOAD = TW'((1 << W_TIMEOUT) - 2);
    state_t state_q;
    logic [7:0] cur_mode_q, last_q, res_mode_q;
    logic cur_sub_q, sub_sweep_q, aborted_q, cfg_err_q, res_sub_q;
    logic [W_DWELL-1:0] dwell_q;
    logic [W_SETTLE-1:0] settle_q;
    logic [1:0] res_flags_q;
    logic [W_RECV-1:0] res_recv_q;
    logic [W_ERR-1:0] res_err_q;
    logic in_sweep, timed_out, capture, tmr_load, tmr_zero;
    logic [TW-1:0] tmr_val, dwell_m1;
    always_comb begin
        in_sweep = state_q != S_IDLE && state_q != S_FINISH;
        timed_out = state_q == S_WAIT_INIT && !bus.phy_init && tmr_zero;
        capture = timed_out || (state_q == S_DWELL && tmr_zero);
        tmr_load = !(state_q inside {S_SETTLE, S_WAIT_INIT, S_DWELL}) || (state_q == S_WAIT_INIT && bus.phy_init);
        dwell_m1 = (dwell_q == '0) ? '0 : TW'(dwell_q) - TW'(1);
        tmr_val = state_q == S_IDLE ? TW'(bus.settle) :
                  state_q == S_CLEAR ? T_LOAD :
                  state_q == S_WAIT_INIT ? dwell_m1 : TW'(settle_q);
    end
    sweep_timer #(.W(TW)) u_timer (
        .clk(clk),
        .rst(rst),
        .load_i(tmr_load),
        .val_i(tmr_val),
        .zero_o(tmr_zero)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cur_mode_q <= '0;
            last_q <= '0;
            cur_sub_q <= 1'b0;
            sub_sweep_q <= 1'b0;
            dwell_q <= '0;
            settle_q <= '0;
            aborted_q <= 1'b0;
            cfg_err_q <= 1'b0;
            res_mode_q <= '0;
            res_sub_q <= 1'b0;
            res_flags_q <= '0;
            res_recv_q <= '0;
            res_err_q <= '0;
        end else if (in_sweep && bus.abort) begin
            state_q <= S_FINISH;
            aborted_q <= 1'b1;
        end else begin
            case (state_q)
                S_IDLE: if (bus.start) begin
                    cur_mode_q <= bus.first_mode;
                    last_q <= bus.last_mode;
                    cur_sub_q <= 1'b0;
                    sub_sweep_q <= bus.sub_sweep;
                    dwell_q <= bus.dwell;
                    settle_q <= bus.settle;
                    aborted_q <= 1'b0;
                    cfg_err_q <= bus.first_mode > bus.last_mode;
                    state_q <= (bus.first_mode > bus.last_mode) ? S_FINISH : S_SETTLE;
                end
                S_SETTLE: if (tmr_zero) state_q <= S_CLEAR;
                S_CLEAR: state_q <= S_WAIT_INIT;
                S_WAIT_INIT: state_q <= bus.phy_init ? S_DWELL : (tmr_zero ? S_REPORT : S_WAIT_INIT);
                S_DWELL: if (tmr_zero) state_q <= S_REPORT;
                S_REPORT: if (bus.res_ready) state_q <= S_NEXT;
                S_NEXT: if (sub_sweep_q && !cur_sub_q) begin
                    cur_sub_q <= 1'b1;
                    state_q <= S_SETTLE;
                end else if (cur_mode_q == last_q) begin
                    state_q <= S_FINISH;
                end else begin
                    cur_mode_q <= cur_mode_q + 8'd1;
                    cur_sub_q <= 1'b0;
                    state_q <= S_SETTLE;
                end
                default: state_q <= S_IDLE;
            endcase
            if (capture) begin
                res_mode_q <= cur_mode_q;
                res_sub_q <= cur_sub_q;
                res_recv_q <= bus.recv_cnt;
                res_err_q <= bus.err_cnt;
                res_flags_q[F_TIMEOUT] <= timed_out;
                res_flags_q[F_ERR] <= bus.err_cnt != '0;
            end
        end
    end
    assign bus.main_mode = in_sweep ? cur_mode_q : 8'd0;
    assign bus.sub_mode = in_sweep ? {7'b0, cur_sub_q} : 8'd0;
    assign bus.clr = state_q == S_CLEAR;
    assign bus.busy = state_q != S_IDLE;
    assign bus.done = state_q == S_FINISH;
    assign bus.aborted = state_q == S_FINISH && aborted_q;
    assign bus.cfg_err = state_q == S_FINISH && cfg_err_q;
    assign bus.res_valid = state_q == S_REPORT;
    assign bus.res_mode = res_mode_q;
    assign bus.res_sub = res_sub_q;
    assign bus.res_flags = res_flags_q;
    assign bus.res_recv = res_recv_q;
    assign bus.res_err = res_err_q;
endmodule

// File: tb/tb_mode_sweeper.sv
// tb_mode_sweeper: directed sweeps with hand-computed results, timing and abort/reset behaviour
module tb_mode_sweeper;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_checks = 0;
    int n_fail = 0;
    always #5 clk = ~clk;
    mode_sweeper_if #(.W_DWELL(16), .W_SETTLE(8)) bus ();
    mode_sweeper #(.W_DWELL(16), .W_SETTLE(8), .W_TIMEOUT(4)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );
    int n_res, n_clr, mm_n, i_clr, i_rep, i_done, bad;
    logic got_done, d_ab, d_cfg;
    logic [7:0] d_mm;
    logic [7:0] r_mode [8];
    logic r_sub [8];
    logic [1:0] r_flags [8];
    logic [59:0] r_recv [8];
    logic [7:0] mm_seq [8];
    logic [7:0] clr_sub [8];
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask
    task automatic cfg(input logic [7:0] f, input logic [7:0] l, input logic s, input logic [7:0] st, input logic [15:0] dw);
        bus.first_mode = f;
        bus.last_mode = l;
        bus.sub_sweep = s;
        bus.settle = st;
        bus.dwell = dw;
    endtask
    task automatic sweep(input int budget);
        n_res = 0; n_clr = 0; mm_n = 0; i_clr = -1; i_rep = -1; i_done = -1;
        got_done = 1'b0; d_ab = 1'b0; d_cfg = 1'b0; d_mm = '0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        for (int i = 0; i < budget && !got_done; i++) begin
            if (bus.clr) begin
                if (n_clr < 8) clr_sub[n_clr] = bus.sub_mode;
                if (i_clr < 0) i_clr = i;
                n_clr++;
            end
            if (bus.res_valid && i_rep < 0) i_rep = i;
            if (bus.res_valid && bus.res_ready) begin
                if (n_res < 8) begin
                    r_mode[n_res] = bus.res_mode;
                    r_sub[n_res] = bus.res_sub;
                    r_flags[n_res] = bus.res_flags;
                    r_recv[n_res] = bus.res_recv;
                end
                n_res++;
            end
            if (mm_n < 8 && bus.main_mode != 0 && (mm_n == 0 || mm_seq[mm_n-1] != bus.main_mode)) begin
                mm_seq[mm_n] = bus.main_mode;
                mm_n++;
            end
            if (bus.done) begin
                got_done = 1'b1; i_done = i;
                d_ab = bus.aborted; d_cfg = bus.cfg_err; d_mm = bus.main_mode;
            end else tick();
        end
        check("done_seen", {63'd0, got_done}, 64'd1);
        tick();
    endtask
    initial begin
        bus.start = 1'b1; bus.abort = 1'b1; bus.phy_init = 1'b1; bus.res_ready = 1'b1;
        bus.recv_cnt = 60'h123456789; bus.err_cnt = '0;
        cfg(8'd3, 8'd5, 1'b0, 8'd2, 16'd10);
        repeat (3) tick();
        check("rst_busy", {63'd0, bus.busy}, 64'd0);
        check("rst_main", {56'd0, bus.main_mode}, 64'd0);
        check("rst_valid", {63'd0, bus.res_valid}, 64'd0);
        check("rst_done", {63'd0, bus.done}, 64'd0);
        check("rst_res_err", bus.res_err, 64'd0);
        bus.start = 1'b0; bus.abort = 1'b0;
        rst = 1'b0;
        tick();
        // three modes, no sub-sweep
        sweep(500);
        check("t1_nres", 64'(n_res), 64'd3);
        check("t1_mode0", {56'd0, r_mode[0]}, 64'd3);
        check("t1_mode1", {56'd0, r_mode[1]}, 64'd4);
        check("t1_mode2", {56'd0, r_mode[2]}, 64'd5);
        check("t1_recv", {4'd0, r_recv[0]}, 64'h123456789);
        check("t1_flags", {62'd0, r_flags[2]}, 64'd0);
        check("t1_nclr", 64'(n_clr), 64'd3);
        check("t1_mmseq", {40'd0, mm_seq[0], mm_seq[1], mm_seq[2]}, 64'h030405);
        check("t1_mm_n", 64'(mm_n), 64'd3);
        check("t1_settle_len", 64'(i_clr), 64'd3);
        check("t1_dwell_len", 64'(i_rep), 64'd15);
        check("t1_aborted", {63'd0, d_ab}, 64'd0);
        check("t1_cfg_err", {63'd0, d_cfg}, 64'd0);
        check("t1_idle", {63'd0, bus.busy}, 64'd0);
        // single mode with sub-sweep; START alongside ABORT in IDLE still starts
        cfg(8'd7, 8'd7, 1'b1, 8'd1, 16'd3);
        bus.abort = 1'b1;
        sweep(300);
        check("t2_nres", 64'(n_res), 64'd2);
        check("t2_res0", {55'd0, r_mode[0], r_sub[0]}, {55'd0, 8'd7, 1'b0});
        check("t2_res1", {55'd0, r_mode[1], r_sub[1]}, {55'd0, 8'd7, 1'b1});
        check("t2_clrsub", {48'd0, clr_sub[0], clr_sub[1]}, 64'h0001);
        check("t2_aborted", {63'd0, d_ab}, 64'd0);
        // PHY_INIT never rises: timeout of 16 cycles
        bus.phy_init = 1'b0;
        cfg(8'd1, 8'd1, 1'b0, 8'd0, 16'd5);
        sweep(300);
        check("t3_nres", 64'(n_res), 64'd1);
        check("t3_timeout_len", 64'(i_rep - i_clr), 64'd16);
        check("t3_flags", {62'd0, r_flags[0]}, 64'd2);
        bus.phy_init = 1'b1;
        // backpressure on the result handshake
        cfg(8'd2, 8'd2, 1'b0, 8'd1, 16'd4);
        bus.err_cnt = 64'd5; bus.recv_cnt = 60'hABC; bus.res_ready = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int k = 0; k < 100 && !bus.res_valid; k++) tick();
        check("t4_report", {63'd0, bus.res_valid}, 64'd1);
        check("t4_err", bus.res_err, 64'd5);
        check("t4_flags", {62'd0, bus.res_flags}, 64'd1);
        check("t4_mode", {56'd0, bus.res_mode}, 64'd2);
        bus.err_cnt = 64'd9;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (!bus.res_valid || bus.res_err != 64'd5 || bus.res_recv != 60'hABC) bad++;
        end
        check("t4_hold", 64'(bad), 64'd0);
        bus.res_ready = 1'b1;
        tick();
        check("t4_xfer", {63'd0, bus.res_valid}, 64'd0);
        for (int k = 0; k < 20 && !bus.done; k++) tick();
        check("t4_done", {63'd0, bus.done}, 64'd1);
        tick();
        bus.err_cnt = '0;
        // reversed range
        cfg(8'd9, 8'd2, 1'b0, 8'd2, 16'd10);
        sweep(10);
        check("t5_cfg_err", {63'd0, d_cfg}, 64'd1);
        check("t5_done_lat", 64'(i_done), 64'd0);
        check("t5_main", {56'd0, d_mm}, 64'd0);
        check("t5_no_mode", 64'(mm_n), 64'd0);
        check("t5_nres", 64'(n_res), 64'd0);
        // LAST_MODE=255 must not wrap
        cfg(8'd254, 8'd255, 1'b0, 8'd0, 16'd1);
        sweep(200);
        check("t6_nres", 64'(n_res), 64'd2);
        check("t6_modes", {48'd0, r_mode[0], r_mode[1]}, 64'hFEFF);
        // abort during DWELL of mode 4
        cfg(8'd3, 8'd6, 1'b0, 8'd2, 16'd10);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bad = 1;
        for (int k = 0; k < 200 && bad != 0; k++) begin
            if (bus.clr && bus.main_mode == 8'd4) bad = 0;
            else tick();
        end
        check("t7_reach_m4", 64'(bad), 64'd0);
        repeat (3) tick();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check("t7_done", {63'd0, bus.done}, 64'd1);
        check("t7_aborted", {63'd0, bus.aborted}, 64'd1);
        check("t7_main", {56'd0, bus.main_mode}, 64'd0);
        check("t7_valid", {63'd0, bus.res_valid}, 64'd0);
        check("t7_clr", {63'd0, bus.clr}, 64'd0);
        tick();
        check("t7_idle", {63'd0, bus.busy}, 64'd0);
        // reset in the middle of a sweep
        cfg(8'd1, 8'd3, 1'b0, 8'd2, 16'd10);
        bus.err_cnt = 64'd7;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (20) tick();
        check("t8_pre_err", bus.res_err, 64'd7);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t8_busy", {63'd0, bus.busy}, 64'd0);
        check("t8_res_err", bus.res_err, 64'd0);
        check("t8_main", {56'd0, bus.main_mode}, 64'd0);
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done || bus.busy) bad++;
            tick();
        end
        check("t8_no_done", 64'(bad), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
